pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline hazard controller for the core's front end. It sequences the PC register, the `if_id` stage register and the `id_ex` stage register by generating hold, flush and redirect controls from jump, load-use, multi-cycle-execute and fetch-ready conditions. A flushed `if_id` loads `INST_NOP_OP` and address `32'b0`. It sits beside the core datapath: inputs come from ID, EX and the fetch bus port, and outputs go to `pc_reg`, `if_id` and `id_ex`.

## Interface
- `IRQ_VEC`, `32'h0000_0100`: interrupt entry address (used only with the macro).
- `CNT_W`, `16`: width of the stall performance counter.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `jump_en_i`  in  1  EX resolves a taken branch or jump this cycle.
- `jump_addr_i`  in  32  target address for `jump_en_i`.
- `load_use_i`  in  1  ID detects a load-use hazard against EX.
- `mc_busy_i`  in  1  EX multi-cycle unit (divider) is busy; level signal.
- `fetch_ready_i`  in  1  instruction bus returns valid data this cycle.
- `id_pc_i`  in  32  `inst_addr_o` of `if_id`; used for EPC.
- `hold_pc_o`, `hold_if_id_o`, `hold_id_ex_o`  out  1 each  freeze the named register.
- `flush_if_id_o`, `flush_id_ex_o`  out  1 each  load NOP/zero into the named register.
- `jump_en_o`  out  1  redirect the PC.
- `jump_addr_o`  out  32  redirect target.
- `stall_cnt_o`  out  CNT_W  saturating count of cycles with `hold_pc_o` high.
- `irq_i`  in  1  interrupt request pulse (macro only).
- `irq_ack_o`  out  1  one-cycle acknowledge (macro only).
- `epc_o`  out  32  saved return PC (macro only).

## Operation
- FSM states: RUN, MC_WAIT, REDIR. The IRQ path adds no state.
- Reset: state RUN. All 1-bit outputs are 0. `jump_addr_o`, `epc_o` and `stall_cnt_o` are 0. The pending-redirect register and the pending-IRQ latch are cleared.
- Outputs are combinational from state plus inputs. Only state, the latched target, the counter and the IRQ latch are registered.
- RUN priority, highest first:
  - `jump_en_i`: assert `jump_en_o`, set `jump_addr_o=jump_addr_i`, assert both flushes. If `fetch_ready_i=0`, latch the target and go to REDIR.
  - `mc_busy_i`: assert all three holds and go to MC_WAIT.
  - `load_use_i`: assert `hold_pc_o` and `hold_if_id_o`, plus `flush_id_ex_o` (one bubble). Stay in RUN.
  - `!fetch_ready_i`: assert `hold_pc_o` and `flush_if_id_o`.
- MC_WAIT:
  - While `mc_busy_i=1`, all three holds stay asserted and `jump_en_i` is ignored.
  - When `mc_busy_i` falls, release the holds in that same cycle and return to RUN. That cycle's other inputs are evaluated as in RUN.
- REDIR:
  - Drive `jump_en_o=1` with the latched target and assert `flush_if_id_o`.
  - On `fetch_ready_i=1`, go to RUN.
  - A new `jump_en_i` in REDIR replaces the latched target; the newest target wins.
- `stall_cnt_o` increments on every cycle with `hold_pc_o=1` and saturates at all-ones.
- `rst` in any state returns the block to the reset values on the next edge, including a reset during a pending redirect.

## Timing
- Zero-cycle control latency: a hazard input affects the hold and flush outputs in the same cycle.
- The redirect takes effect at the next clock edge.
- A load-use hazard costs exactly 1 stall cycle per assertion.
- MC_WAIT costs N cycles for N cycles of `mc_busy_i`.
- In the cycle where a jump and `load_use_i` coincide, the jump wins and no hold is asserted.

## Configuration
- Macro: `PIPE_CTRL_IRQ_EN`.
- Defined:
  - `irq_i` sets a pending latch.
  - The interrupt is taken in RUN only when `jump_en_i`, `mc_busy_i` and `load_use_i` are all 0.
  - Taking it: `jump_en_o=1`, `jump_addr_o=IRQ_VEC`, both flushes, `epc_o<=id_pc_i`, a 1-cycle `irq_ack_o`, and the latch is cleared.
  - If `fetch_ready_i=0` when taken, go to REDIR with the target `IRQ_VEC`.
- Undefined: the `irq_i`, `irq_ack_o` and `epc_o` ports and the latch do not exist.

## Structure
- Shared package `pipe_ctrl_pkg`: the state encoding (RUN=2'd0, MC_WAIT=2'd1, REDIR=2'd2) and the `INST_NOP_OP` constant (kept consistent with `defines.v`).
- One sub-module: `sat_counter` (parameterised width, increment enable, synchronous reset), used for `stall_cnt_o`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all inputs 1. All outputs read 0 and state is RUN.
- **Jump with fetch ready:** `jump_en_i=1`, `jump_addr_i=32'h0000_0040`, `fetch_ready_i=1` for 1 cycle. Same cycle: `jump_en_o=1`, `jump_addr_o=0x40`, `flush_if_id_o=1`, `flush_id_ex_o=1`. Next cycle: all of these are 0.
- **Load-use:** pulse `load_use_i` for 1 cycle. Exactly 1 cycle of `hold_pc_o`, `hold_if_id_o` and `flush_id_ex_o`, and `stall_cnt_o` reads 1 afterwards.
- **Divider:** `mc_busy_i` high for 5 cycles, with `jump_en_i` pulsed during cycle 3. All holds are high for 5 cycles, the jump is ignored, and `stall_cnt_o` rises by 5.
- **Redirect under fetch wait:** jump to `0x80` with `fetch_ready_i=0` for 3 cycles, plus a second jump to `0xC0` in cycle 2. `jump_en_o` stays high with `jump_addr_o=0xC0` until the cycle where `fetch_ready_i=1`.
- **IRQ (macro defined):** `irq_i` pulse while `load_use_i=1`, with `id_pc_i=0x24`. Acknowledge comes one cycle after `load_use_i` drops, with `jump_addr_o=0x100` and `epc_o=0x24`.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the front-end hazard controller: FSM encoding,
// the NOP opcode loaded into a flushed if_id, and the packed control bundle.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MC_WAIT = 2'd1;
    localparam logic [1:0] ST_REDIR   = 2'd2;

    // Must match INST_NOP_OP in defines.v.
    localparam logic [6:0] INST_NOP_OP = 7'b0000001;

    typedef struct packed {
        logic        hold_pc;
        logic        hold_if_id;
        logic        hold_id_ex;
        logic        flush_if_id;
        logic        flush_id_ex;
        logic        jump_en;
        logic [31:0] jump_addr;
    } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with increment enable and synchronous reset that sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc_en && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Front-end hazard controller: hold/flush/redirect for pc_reg, if_id and id_ex.
// Optional interrupt entry path is built when PIPE_CTRL_IRQ_EN is defined.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | normal issue; jump > mc_busy > load_use > irq > fetch wait
// ST_MC_WAIT | divider busy, all stages frozen, jumps ignored
// ST_REDIR   | redirect issued but fetch not ready; keep driving the target
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = 32'h0000_0100,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             load_use_i,
    input  logic             mc_busy_i,
    input  logic             fetch_ready_i,
    input  logic [31:0]      id_pc_i,
`ifdef PIPE_CTRL_IRQ_EN
    input  logic             irq_i,
    output logic             irq_ack_o,
    output logic [31:0]      epc_o,
`endif
    output logic             hold_pc_o,
    output logic             hold_if_id_o,
    output logic             hold_id_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [1:0]  state_q;
    logic [1:0]  state_nxt;
    logic [31:0] tgt_q;
    logic [31:0] tgt_nxt;
    logic        run_eval;
    logic        irq_req;
    logic        irq_take;
    ctrl_t       ctrl;

`ifdef PIPE_CTRL_IRQ_EN
    logic        irq_pend_q;
    logic [31:0] epc_q;

    assign irq_req = irq_pend_q;
`else
    logic        unused_cfg;

    assign irq_req    = 1'b0;
    assign unused_cfg = ^{id_pc_i, IRQ_VEC, irq_take};
`endif

    always_comb begin
        ctrl      = '0;
        state_nxt = state_q;
        tgt_nxt   = tgt_q;
        run_eval  = 1'b0;
        irq_take  = 1'b0;

        case (state_q)
            ST_MC_WAIT: begin
                if (mc_busy_i) begin
                    ctrl.hold_pc    = 1'b1;
                    ctrl.hold_if_id = 1'b1;
                    ctrl.hold_id_ex = 1'b1;
                end else begin
                    run_eval = 1'b1;
                end
            end
            ST_REDIR: begin
                ctrl.jump_en     = 1'b1;
                ctrl.flush_if_id = 1'b1;
                ctrl.jump_addr   = tgt_q;
                // A later EX jump supersedes the pending target.
                if (jump_en_i) begin
                    ctrl.jump_addr   = jump_addr_i;
                    ctrl.flush_id_ex = 1'b1;
                    tgt_nxt          = jump_addr_i;
                end
                if (fetch_ready_i) begin
                    state_nxt = ST_RUN;
                end
            end
            default: run_eval = 1'b1;
        endcase

        if (run_eval) begin
            state_nxt = ST_RUN;
            if (jump_en_i) begin
                ctrl.jump_en     = 1'b1;
                ctrl.jump_addr   = jump_addr_i;
                ctrl.flush_if_id = 1'b1;
                ctrl.flush_id_ex = 1'b1;
            end else if (mc_busy_i) begin
                ctrl.hold_pc    = 1'b1;
                ctrl.hold_if_id = 1'b1;
                ctrl.hold_id_ex = 1'b1;
                state_nxt       = ST_MC_WAIT;
            end else if (load_use_i) begin
                ctrl.hold_pc     = 1'b1;
                ctrl.hold_if_id  = 1'b1;
                ctrl.flush_id_ex = 1'b1;
            end else if (irq_req) begin
                irq_take         = 1'b1;
                ctrl.jump_en     = 1'b1;
                ctrl.jump_addr   = IRQ_VEC;
                ctrl.flush_if_id = 1'b1;
                ctrl.flush_id_ex = 1'b1;
            end else if (!fetch_ready_i) begin
                ctrl.hold_pc     = 1'b1;
                ctrl.flush_if_id = 1'b1;
            end
            if (ctrl.jump_en && !fetch_ready_i) begin
                state_nxt = ST_REDIR;
                tgt_nxt   = ctrl.jump_addr;
            end
        end

        // Outputs are quiet while reset is applied, whatever the inputs do.
        if (rst) begin
            ctrl     = '0;
            irq_take = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            tgt_q   <= tgt_nxt;
        end
    end

`ifdef PIPE_CTRL_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_pend_q <= 1'b0;
            epc_q      <= '0;
        end else begin
            irq_pend_q <= (irq_pend_q & ~irq_take) | irq_i;
            if (irq_take) begin
                epc_q <= id_pc_i;
            end
        end
    end

    assign irq_ack_o = irq_take;
    assign epc_o     = epc_q;
`endif

    assign hold_pc_o     = ctrl.hold_pc;
    assign hold_if_id_o  = ctrl.hold_if_id;
    assign hold_id_ex_o  = ctrl.hold_id_ex;
    assign flush_if_id_o = ctrl.flush_if_id;
    assign flush_id_ex_o = ctrl.flush_id_ex;
    assign jump_en_o     = ctrl.jump_en;
    assign jump_addr_o   = ctrl.jump_addr;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (ctrl.hold_pc),
        .count  (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios then random
// traffic, compared each cycle against a behavioural model of the control rules.
module tb_pipe_ctrl;

    localparam int          TB_CNT_W = 4;
    localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;
    localparam logic [31:0] TB_IRQ_VEC = 32'h0000_0100;
`ifdef PIPE_CTRL_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, jump_en_i, load_use_i, mc_busy_i, fetch_ready_i, irq_i;
    logic [31:0] jump_addr_i, id_pc_i;
    logic hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o, jump_en_o;
    logic [31:0] jump_addr_o;
    logic [TB_CNT_W-1:0] stall_cnt_o;
    logic irq_ack_w;
    logic [31:0] epc_w;

    int unsigned total = 0;
    int unsigned bad = 0;

    // behavioural model state
    bit          m_redir, m_div, m_irq;
    logic [31:0] m_tgt, m_epc;
    int          m_cnt;
    logic        e_hpc, e_hif, e_hex, e_fif, e_fex, e_jen, e_ack;
    logic [31:0] e_addr;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .IRQ_VEC (TB_IRQ_VEC),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .load_use_i    (load_use_i),
        .mc_busy_i     (mc_busy_i),
        .fetch_ready_i (fetch_ready_i),
        .id_pc_i       (id_pc_i),
`ifdef PIPE_CTRL_IRQ_EN
        .irq_i         (irq_i),
        .irq_ack_o     (irq_ack_w),
        .epc_o         (epc_w),
`endif
        .hold_pc_o     (hold_pc_o),
        .hold_if_id_o  (hold_if_id_o),
        .hold_id_ex_o  (hold_id_ex_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .jump_en_o     (jump_en_o),
        .jump_addr_o   (jump_addr_o),
        .stall_cnt_o   (stall_cnt_o)
    );

`ifndef PIPE_CTRL_IRQ_EN
    assign irq_ack_w = 1'b0;
    assign epc_w     = 32'h0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval();
        {e_hpc, e_hif, e_hex, e_fif, e_fex, e_jen, e_ack} = '0;
        e_addr = 32'h0;
        if (rst) begin
            // everything quiet
        end else if (m_redir) begin
            e_jen = 1'b1;
            e_fif = 1'b1;
            e_addr = jump_en_i ? jump_addr_i : m_tgt;
            e_fex = jump_en_i;
        end else if (m_div && mc_busy_i) begin
            {e_hpc, e_hif, e_hex} = 3'b111;
        end else if (jump_en_i) begin
            {e_jen, e_fif, e_fex} = 3'b111;
            e_addr = jump_addr_i;
        end else if (mc_busy_i) begin
            {e_hpc, e_hif, e_hex} = 3'b111;
        end else if (load_use_i) begin
            {e_hpc, e_hif, e_fex} = 3'b111;
        end else if (IRQ_ON && m_irq) begin
            {e_jen, e_fif, e_fex, e_ack} = 4'b1111;
            e_addr = TB_IRQ_VEC;
        end else if (!fetch_ready_i) begin
            {e_hpc, e_fif} = 2'b11;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_redir = 1'b0; m_div = 1'b0; m_irq = 1'b0;
            m_tgt = 32'h0; m_epc = 32'h0; m_cnt = 0;
        end else begin
            if (e_hpc && m_cnt < CNT_MAX) m_cnt++;
            if (e_ack) m_epc = id_pc_i;
            m_irq = (m_irq && !e_ack) || (IRQ_ON && irq_i);
            m_div = e_hex;
            if (e_jen && !fetch_ready_i) begin
                m_redir = 1'b1;
                m_tgt = e_addr;
            end else if (m_redir && fetch_ready_i) begin
                m_redir = 1'b0;
            end
        end
    endtask

    // One clock: drive inputs just after the edge, check mid-cycle, advance model.
    task automatic cyc(input logic r, input logic je, input logic [31:0] ja, input logic lu,
                       input logic mb, input logic fr, input logic [31:0] pc, input logic ir);
        rst = r; jump_en_i = je; jump_addr_i = ja; load_use_i = lu;
        mc_busy_i = mb; fetch_ready_i = fr; id_pc_i = pc; irq_i = ir;
        model_eval();
        #3;
        chk("flags", {25'h0, hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o,
                      flush_id_ex_o, jump_en_o, irq_ack_w},
                     {25'h0, e_hpc, e_hif, e_hex, e_fif, e_fex, e_jen, e_ack});
        chk("jump_addr", jump_addr_o, e_addr);
        chk("stall_cnt", {28'h0, stall_cnt_o}, m_cnt);
        chk("epc", epc_w, m_epc);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 32'h0, 0, 0, 1, 32'h0, 0);
    endtask

    initial begin
        logic mb_lvl;
        rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = 32'h0; load_use_i = 1'b0;
        mc_busy_i = 1'b0; fetch_ready_i = 1'b1; id_pc_i = 32'h0; irq_i = 1'b0;
        m_redir = 1'b0; m_div = 1'b0; m_irq = 1'b0; m_tgt = 32'h0; m_epc = 32'h0; m_cnt = 0;
        @(posedge clk);
        #1;

        // reset with every input high
        cyc(1, 1, 32'hFFFF_FFFF, 1, 1, 1, 32'hFFFF_FFFF, 1);
        cyc(1, 1, 32'hFFFF_FFFF, 1, 1, 1, 32'hFFFF_FFFF, 1);
        idle(1);

        // jump with fetch ready
        cyc(0, 1, 32'h0000_0040, 0, 0, 1, 32'h0, 0);
        idle(1);

        // load-use single bubble
        cyc(0, 0, 32'h0, 1, 0, 1, 32'h0, 0);
        idle(2);

        // divider busy 5 cycles, jump ignored in cycle 3
        cyc(0, 0, 32'h0,         0, 1, 1, 32'h0, 0);
        cyc(0, 0, 32'h0,         0, 1, 1, 32'h0, 0);
        cyc(0, 1, 32'h0000_0200, 0, 1, 1, 32'h0, 0);
        cyc(0, 0, 32'h0,         0, 1, 1, 32'h0, 0);
        cyc(0, 0, 32'h0,         0, 1, 1, 32'h0, 0);
        idle(2);

        // redirect under fetch wait, newest target wins
        cyc(0, 1, 32'h0000_0080, 0, 0, 0, 32'h0, 0);
        cyc(0, 1, 32'h0000_00C0, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0,         0, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0,         0, 0, 1, 32'h0, 0);
        idle(1);

        // jump coinciding with load-use: no hold
        cyc(0, 1, 32'h0000_0300, 1, 0, 1, 32'h0, 0);
        idle(1);

        // reset while a redirect is pending
        cyc(0, 1, 32'h0000_0400, 0, 0, 0, 32'h0, 0);
        cyc(1, 0, 32'h0,         0, 0, 0, 32'h0, 0);
        idle(2);

        if (IRQ_ON) begin
            cyc(0, 0, 32'h0, 1, 0, 1, 32'h0000_0024, 1);
            cyc(0, 0, 32'h0, 0, 0, 1, 32'h0000_0024, 0);
            idle(2);
            cyc(0, 0, 32'h0, 0, 0, 1, 32'h0000_0050, 1);
            cyc(0, 0, 32'h0, 0, 0, 0, 32'h0000_0054, 0);
            cyc(0, 0, 32'h0, 0, 0, 0, 32'h0000_0054, 0);
            idle(2);
        end

        // random traffic; CNT_W is small so saturation is reached
        mb_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) mb_lvl = ~mb_lvl;
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 6) == 0),
                $urandom,
                ($urandom_range(0, 6) == 0),
                mb_lvl,
                ($urandom_range(0, 3) != 0),
                $urandom,
                ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
